tmds_encoder: RTL

//  DVI/HDMI TMDS 8b/10b channel encoder on the pixel_clk domain.
//  - Video periods: transition-minimised, DC-balanced encoding.
//  - Blanking: the four control tokens.
//  - Output tmds_data[9:0] feeds the per-channel 10:1 OSERDES serializer; bit 0 is transmitted first.
//  - One instance per channel (blue carries hsync/vsync on ctrl).

---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_qm_stage.sv | 52 +++++
 rtl/tmds_encoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// TMDS encoder shared types, control tokens and TERC4 table.
// Optional TERC4 data-island path: define TMDS_ENC_TERC4_EN.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;
  typedef logic [8:0] qm_t;

  localparam tmds_sym_t CTRL_TOKEN [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam tmds_sym_t TERC4_LUT [16] = '{
    10'b1010011100, 10'b1001100011,
    10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001,
    10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001,
    10'b0101100011, 10'b1011000011
  };

  function automatic logic [3:0] popcount8(
    input logic [7:0] v
  );
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      s = s + {3'b000, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// TMDS stage 1: transition-minimising XOR/XNOR chain.
// Registers q_m together with the matching de/ctrl.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_de,
  input  logic [1:0] i_ctrl,
  output qm_t        o_qm,
  output logic       o_de,
  output logic [1:0] o_ctrl
);

  logic [3:0] w_n1d;
  logic       w_xnor;
  qm_t        w_qm;
  qm_t        r_qm;
  logic       r_de;
  logic [1:0] r_ctrl;

  assign w_n1d  = popcount8(i_data);
  assign w_xnor = (w_n1d > 4'd4) ||
                  (w_n1d == 4'd4 && !i_data[0]);

  always_comb begin
    w_qm    = '0;
    w_qm[0] = i_data[0];
    for (int i = 1; i < 8; i++)
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_data[i])
                       :  (w_qm[i-1] ^ i_data[i]);
    w_qm[8] = ~w_xnor;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qm   <= '0;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      r_qm   <= w_qm;
      r_de   <= i_de;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_qm   = r_qm;
  assign o_de   = r_de;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: stage 2, disparity and token mux.
// Define TMDS_ENC_TERC4_EN to enable the TERC4 data-island path.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic [7:0] vid_data,
  input  logic       vid_de,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux_data,
  input  logic       aux_de,
  output logic [9:0] tmds_data
);

  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);

  qm_t        w_qm;
  logic       w_de;
  logic [1:0] w_ctrl;
  logic       w_q8;
  logic [7:0] w_q;
  logic [3:0] w_n1;

  logic signed [CNT_W-1:0] w_n1s;
  logic signed [CNT_W-1:0] w_n0s;
  logic signed [CNT_W-1:0] w_diff;
  logic signed [CNT_W-1:0] w_cnt_nxt;
  logic signed [CNT_W-1:0] r_cnt;
  tmds_sym_t               w_sym;
  tmds_sym_t               r_tmds;

  tmds_qm_stage u_qm (
    .i_clk   (pixel_clk),
    .i_rst_n (rst_n),
    .i_data  (vid_data),
    .i_de    (vid_de),
    .i_ctrl  (ctrl),
    .o_qm    (w_qm),
    .o_de    (w_de),
    .o_ctrl  (w_ctrl)
  );

`ifdef TMDS_ENC_TERC4_EN
  logic       r_aux_de;
  logic [3:0] r_aux_data;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aux_de   <= 1'b0;
      r_aux_data <= '0;
    end else begin
      r_aux_de   <= aux_de;
      r_aux_data <= aux_data;
    end
  end
`else
  logic w_unused_aux;
  assign w_unused_aux = ^{aux_data, aux_de};
`endif

  assign w_q8   = w_qm[8];
  assign w_q    = w_qm[7:0];
  assign w_n1   = popcount8(w_q);
  assign w_n1s  = signed'(CNT_W'(w_n1));
  assign w_n0s  = signed'(CNT_W'(4'd8 - w_n1));
  assign w_diff = w_n1s - w_n0s;

  // cnt tracks the ones-minus-zeros of every emitted video symbol
  always_comb begin
    w_sym     = CTRL_TOKEN[w_ctrl];
    w_cnt_nxt = ZERO;
    if (w_de) begin
      if (r_cnt == ZERO || w_diff == ZERO) begin
        w_sym     = {~w_q8, w_q8, w_q8 ? w_q : ~w_q};
        w_cnt_nxt = w_q8 ? r_cnt + w_diff
                         : r_cnt - w_diff;
      end else if ((r_cnt > ZERO && w_diff > ZERO) ||
                   (r_cnt < ZERO && w_diff < ZERO)) begin
        w_sym     = {1'b1, w_q8, ~w_q};
        w_cnt_nxt = r_cnt + (w_q8 ? TWO : ZERO) - w_diff;
      end else begin
        w_sym     = {1'b0, w_q8, w_q};
        w_cnt_nxt = r_cnt - (w_q8 ? ZERO : TWO) + w_diff;
      end
    end
`ifdef TMDS_ENC_TERC4_EN
    else if (r_aux_de) begin
      w_sym = TERC4_LUT[r_aux_data];
    end
`endif
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmds <= CTRL_TOKEN[0];
      r_cnt  <= ZERO;
    end else begin
      r_tmds <= w_sym;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign tmds_data = r_tmds;

endmodule
